// File: rtl/dm_pipelined_if.sv
// Request/response bus of the MEM-stage data memory.
// master: the pipeline side (drives requests, receives responses and init_done).
// slave : the memory side.
//   req_valid/req_ready   handshake, accepted when both high
//   req_we/req_size       store flag and access size code
//   req_addr/req_wdata    byte address and low-aligned store data
//   req_pc                PC of the issuing instruction, for the write trace
//   rsp_valid/rsp_rdata   one response strobe per accepted request, load data
//   rsp_exc/rsp_exc_code  fault flag and cause
//   init_done             high once the array has been zeroed
interface dm_pipelined_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;
    logic [1:0]  rsp_exc_code;
    logic        init_done;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, req_pc,
        input  req_ready, rsp_valid, rsp_rdata, rsp_exc, rsp_exc_code, init_done
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, req_pc,
        output req_ready, rsp_valid, rsp_rdata, rsp_exc, rsp_exc_code, init_done
    );
endinterface

// File: rtl/dm_pipelined.sv
// Parametrised data memory for the pipelined CPU's MEM stage.
// Sized/aligned loads and stores against a base-address window, exception
// reporting, a READ_LAT-deep response pipeline, and a hardware sequencer that
// zeroes the array one word per cycle after reset.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    dm_pipelined_if.slave (request/response handshake and init_done)
module dm_pipelined #(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic clk,
    input  logic reset,
    dm_pipelined_if.slave bus
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_ALIGN = 2'b01;
    localparam logic [1:0] EXC_RANGE = 2'b10;
    localparam logic [1:0] EXC_SIZE  = 2'b11;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        exc;
        logic [1:0]  code;
    } rsp_t;

    logic [31:0]   mem_q [DEPTH];
    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;
    rsp_t          pipe_q [READ_LAT];

    logic          init_wr_c;
    logic          accept_c;
    logic          st_commit_c;
    logic [31:0]   offset_c;
    logic [AW-1:0] idx_c;
    logic [31:0]   old_word_c;
    logic [31:0]   lane_c;
    logic [31:0]   load_c;
    logic [31:0]   merged_c;
    logic          ill_c;
    logic          misal_c;
    logic          oor_c;
    logic          exc_c;
    logic [1:0]    exc_code_c;
    rsp_t          rsp_new_c;

    // Init/run sequencing: INIT zeroes one word per cycle, then RUN forever.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_wr_c = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_wr_c = 1'b1;
                cnt_d     = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        run_d = (state_d == ST_RUN);
    end

    // Address decode and exception classification, in priority order.
    always_comb begin
        offset_c   = bus.req_addr - BASE_ADDR;
        idx_c      = offset_c[AW+1:2];
        old_word_c = mem_q[idx_c];
        lane_c     = old_word_c >> {bus.req_addr[1:0], 3'b000};
        ill_c      = (bus.req_size > 3'd4);
        case (bus.req_size)
            3'd0:       misal_c = (bus.req_addr[1:0] != 2'b00);
            3'd1, 3'd2: misal_c = bus.req_addr[0];
            default:    misal_c = 1'b0;
        endcase
        // 33-bit compare so a window at the top of the address map cannot wrap.
        oor_c = (bus.req_addr < BASE_ADDR) || ({1'b0, offset_c} >= SPAN);
        if (ill_c) begin
            exc_code_c = EXC_SIZE;
        end else if (misal_c) begin
            exc_code_c = EXC_ALIGN;
        end else if (oor_c) begin
            exc_code_c = EXC_RANGE;
        end else begin
            exc_code_c = EXC_NONE;
        end
        exc_c = (exc_code_c != EXC_NONE);
    end

    // Load lane extraction with sign/zero extension.
    always_comb begin
        case (bus.req_size)
            3'd0:    load_c = old_word_c;
            3'd1:    load_c = {{16{lane_c[15]}}, lane_c[15:0]};
            3'd2:    load_c = {16'h0000, lane_c[15:0]};
            3'd3:    load_c = {{24{lane_c[7]}}, lane_c[7:0]};
            3'd4:    load_c = {24'h00_0000, lane_c[7:0]};
            default: load_c = 32'h0000_0000;
        endcase
    end

    // Store read-modify-write merge; untouched lanes keep the old bytes.
    always_comb begin
        merged_c = old_word_c;
        case (bus.req_size)
            3'd0: merged_c = bus.req_wdata;
            3'd1, 3'd2: begin
                if (bus.req_addr[1]) begin
                    merged_c[31:16] = bus.req_wdata[15:0];
                end else begin
                    merged_c[15:0] = bus.req_wdata[15:0];
                end
            end
            3'd3, 3'd4: merged_c[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
            default: merged_c = old_word_c;
        endcase
    end

    // Response entering the latency pipeline this cycle.
    always_comb begin
        accept_c        = bus.req_valid && run_q && !reset;
        st_commit_c     = accept_c && bus.req_we && !exc_c;
        rsp_new_c       = '0;
        rsp_new_c.valid = accept_c;
        if (accept_c) begin
            rsp_new_c.exc  = exc_c;
            rsp_new_c.code = exc_code_c;
            if (!bus.req_we && !exc_c) begin
                rsp_new_c.rdata = load_c;
            end
        end
    end

    // State, counter and response pipeline; reset drops in-flight responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            pipe_q[0] <= rsp_new_c;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Array writes: init zeroing or store commit (never in the same cycle).
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_wr_c) begin
                mem_q[cnt_q] <= '0;
            end else if (st_commit_c) begin
                mem_q[idx_c] <= merged_c;
            end
        end
    end

`ifndef SYNTHESIS
    // Write trace for simulation logs.
    always_ff @(posedge clk) begin
        if (!reset && st_commit_c) begin
            $display("[DM] t=%0t pc=%08h addr=%08h data=%08h",
                     $time, bus.req_pc, {bus.req_addr[31:2], 2'b00}, merged_c);
        end
    end
`endif

    assign bus.req_ready    = run_q;
    assign bus.init_done    = run_q;
    assign bus.rsp_valid    = pipe_q[READ_LAT-1].valid;
    assign bus.rsp_rdata    = pipe_q[READ_LAT-1].rdata;
    assign bus.rsp_exc      = pipe_q[READ_LAT-1].exc;
    assign bus.rsp_exc_code = pipe_q[READ_LAT-1].code;

endmodule

// File: doc/dm_pipelined.md
Name: dm_pipelined

Overview:
Parametrised data memory for the pipelined CPU's MEM stage, the successor of the fixed 4096-word DM. It adds a valid/ready request port with a configurable response latency (READ_LAT), sized and aligned loads/stores with exception reporting, and a base-address window. Reset no longer clears the array in one cycle: a hardware init sequencer zeroes it one word per cycle.

Parameters:
DEPTH, 4096, number of 32-bit words (power of two, >=2)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (DEPTH*4 aligned)
READ_LAT, 1, cycles from request accept to response (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; clock clk
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1=store, 0=load
req_size  in  3  000 word; 001 half signed; 010 half unsigned; 011 byte signed; 100 byte unsigned; stores: 000 word, 001/010 half, 011/100 byte
req_addr  in  32  byte address
req_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0])
req_pc  in  32  PC of issuing instruction, for the write trace
rsp_valid  out  1  response strobe, one cycle per accepted request
rsp_rdata  out  32  load result, extended per req_size; 0 for stores and exceptions
rsp_exc  out  1  request faulted
rsp_exc_code  out  2  01 misaligned, 10 out of range, 11 illegal size, 00 none
init_done  out  1  high once the array is zeroed

Behaviour:
- FSM states INIT, RUN. Reset (any state, any cycle) -> INIT, init counter=0, all pipeline valid bits cleared; in-flight responses are dropped, never delivered.
- Outputs during and after reset: req_ready=0, init_done=0, rsp_valid=0, rsp_rdata=0, rsp_exc=0, rsp_exc_code=00.
- INIT: writes 0 to word[counter] each cycle, counter+1; after word DEPTH-1 is written -> RUN. INIT lasts exactly DEPTH cycles after reset deasserts.
- RUN: req_ready=1 and init_done=1 continuously; one request accepted per cycle, no backpressure.
- Word index = (req_addr-BASE_ADDR)[log2(DEPTH)+1:2].
- Exception checks at accept, priority: illegal size (101-111) > misaligned (half: addr[0]!=0; word: addr[1:0]!=0) > out of range (addr<BASE_ADDR or addr>=BASE_ADDR+DEPTH*4).
- Faulting requests never write memory; the response still arrives at the normal latency with rdata=0.
- Store: read-modify-write merge into the addressed word, committed at the accept edge.
  - half: lanes [15:0] or [31:16] chosen by addr[1]
  - byte: lane addr[1:0]
  - all other bytes unchanged
- Simulation-only write trace on every commit: time, req_pc, word-aligned address, merged word.
- Load: word sampled at the accept edge, lane selected by addr[1:0], sign- or zero-extended per req_size.
- Response for the request accepted at edge t appears with rsp_valid=1 during cycle t+READ_LAT, through a READ_LAT-deep shift pipeline. Stores also respond (ack, rdata=0). Responses keep request order.
- Ordering: a store accepted at edge t is visible to a load accepted at edge t+1 or later, so back-to-back store->load to the same word returns the new data without forwarding logic.
- Requests with req_valid=1 while req_ready=0 are ignored, with no side effects.

Test Plan:
- DEPTH=16, reset 1 cycle then release -> req_ready/init_done low exactly 16 cycles, then high; every word reads 0.
- sw 0x12345678 @0x0, next cycle lb @0x3 -> rdata 0x00000012; lbu @0x0 -> 0x00000078; lh @0x2 -> 0x00001234.
- sb 0x80 @0x1, then lb @0x1 -> 0xFFFFFF80; lw @0x0 -> 0x12348078; sh 0xBEEF @0x2, lhu @0x2 -> 0x0000BEEF.
- lw @0x2 -> rsp_exc=1 code 01; sh @0x1 -> code 01 and memory unchanged; size 3'b110 -> code 11; lw @BASE+DEPTH*4 -> code 10.
- READ_LAT=3: sw @0x4, lw @0x4, lw @0x8 on consecutive cycles -> three responses on consecutive cycles starting 3 cycles after the first accept, in order, second returns the stored word.
- Assert reset with two loads in flight -> no rsp_valid afterwards, INIT restarts from word 0, previously stored data reads 0 after init.
